// File: rtl/axis_switch_sequencer_if.sv
// AXI-Stream bundle (data, valid, ready) shared by the sequencer's slave and master sides.
// The master modport drives data and valid. The slave modport drives ready.
interface axis_switch_sequencer_if #(
  parameter int AXIS_TDATA_WIDTH = 32
);
  logic [AXIS_TDATA_WIDTH-1:0] tdata;
  logic                        tvalid;
  logic                        tready;

  modport master (output tdata, output tvalid, input  tready);
  modport slave  (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/axis_switch_sequencer.sv
// Applies half-swap requests to the downstream data switch only on block boundaries; zero-latency stream path.
// Backpressure passes straight through, and the stream is stalled for SETTLE_CYCLES after each swap.
// Optional: AXIS_SWITCH_SEQUENCER_COUNT_EN adds a 32-bit swap_count output.
module axis_switch_sequencer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNT_WIDTH        = 16,
  parameter int SETTLE_CYCLES    = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cfg_switch,
  input  logic [CNT_WIDTH-1:0]  cfg_length,
  output logic                  switch,
  output logic                  busy,
`ifdef AXIS_SWITCH_SEQUENCER_COUNT_EN
  output logic [31:0]           swap_count,
`endif
  axis_switch_sequencer_if.slave  s_axis,
  axis_switch_sequencer_if.master m_axis
);

  localparam int SCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SCNT_W-1:0] SCNT_INIT =
    (SETTLE_CYCLES > 0) ? SCNT_W'(SETTLE_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PEND   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [SCNT_W-1:0]    scnt, scnt_nxt;
  logic                 switch_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] len_m1;
  logic                 gate;
  logic                 beat;
  logic                 boundary;

  assign gate          = (state == ST_SETTLE);
  assign m_axis.tvalid = s_axis.tvalid & ~gate;
  assign s_axis.tready = m_axis.tready & ~gate;
  assign m_axis.tdata  = s_axis.tdata;

  assign beat = m_axis.tvalid & m_axis.tready;

  // Length is compared live. The >= comparison closes the block at once if the length shrinks below cnt.
  assign len_m1   = (cfg_length == '0) ? '0 : cfg_length - 1'b1;
  assign boundary = beat & (cnt >= len_m1);

  assign busy = (state != ST_RUN);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (beat) begin
      cnt <= boundary ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    scnt_nxt   = scnt;
    switch_nxt = switch;
    case (state)
      ST_RUN: begin
        // A boundary in this same cycle is not used; the swap waits for the next boundary.
        if (cfg_switch != switch) state_nxt = ST_PEND;
      end
      ST_PEND: begin
        if (cfg_switch == switch) begin
          state_nxt = ST_RUN;
        end else if (boundary) begin
          switch_nxt = cfg_switch;
          if (SETTLE_CYCLES > 0) begin
            state_nxt = ST_SETTLE;
            scnt_nxt  = SCNT_INIT;
          end else begin
            state_nxt = ST_RUN;
          end
        end
      end
      ST_SETTLE: begin
        if (scnt == '0) state_nxt = ST_RUN;
        else            scnt_nxt  = scnt - 1'b1;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= ST_RUN;
      scnt   <= '0;
      switch <= 1'b0;
    end else begin
      state  <= state_nxt;
      scnt   <= scnt_nxt;
      switch <= switch_nxt;
    end
  end

`ifdef AXIS_SWITCH_SEQUENCER_COUNT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      swap_count <= '0;
    end else if (switch_nxt != switch) begin
      swap_count <= swap_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_switch_sequencer.sv
// Directed bench for axis_switch_sequencer (SETTLE_CYCLES=2). Inputs change on the falling edge, and outputs are sampled 1ns later.
module tb_axis_switch_sequencer;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          aclk    = 1'b0;
  logic          aresetn = 1'b0;
  logic          cfg_switch;
  logic [CW-1:0] cfg_length;
  logic          switch;
  logic          busy;
`ifdef AXIS_SWITCH_SEQUENCER_COUNT_EN
  logic [31:0]   swap_count;
`endif
  int checks = 0;
  int errors = 0;

  axis_switch_sequencer_if #(.AXIS_TDATA_WIDTH(DW)) s_axis ();
  axis_switch_sequencer_if #(.AXIS_TDATA_WIDTH(DW)) m_axis ();

  always #5 aclk = ~aclk;

  axis_switch_sequencer #(
    .AXIS_TDATA_WIDTH(DW),
    .CNT_WIDTH       (CW),
    .SETTLE_CYCLES   (2)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .cfg_switch(cfg_switch),
    .cfg_length(cfg_length),
    .switch    (switch),
    .busy      (busy),
`ifdef AXIS_SWITCH_SEQUENCER_COUNT_EN
    .swap_count(swap_count),
`endif
    .s_axis    (s_axis),
    .m_axis    (m_axis)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, check outputs against hand-derived state, then advance to the next falling edge.
  task automatic step(input string tag, input logic sw, input logic rdy,
                      input logic exp_sw, input logic exp_busy, input logic gated);
    cfg_switch    = sw;
    m_axis.tready = rdy;
    s_axis.tdata  = $urandom;
    #1;
    check_eq({tag, ".switch"},   32'(switch),        32'(exp_sw));
    check_eq({tag, ".busy"},     32'(busy),          32'(exp_busy));
    check_eq({tag, ".m_tvalid"}, 32'(m_axis.tvalid), 32'(s_axis.tvalid & ~gated));
    check_eq({tag, ".s_tready"}, 32'(s_axis.tready), 32'(m_axis.tready & ~gated));
    check_eq({tag, ".tdata"},    m_axis.tdata,       s_axis.tdata);
    @(negedge aclk);
  endtask

  task automatic do_reset(input logic [CW-1:0] len);
    aresetn       = 1'b0;
    cfg_switch    = 1'b0;
    cfg_length    = len;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = '0;
    m_axis.tready = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  initial begin
    // Reset values, checked while reset is held.
    cfg_switch    = 1'b0;
    cfg_length    = 16'd4;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = 32'hA5A5_0001;
    m_axis.tready = 1'b1;
    #2;
    check_eq("rst.switch",   32'(switch),        32'd0);
    check_eq("rst.busy",     32'(busy),          32'd0);
    check_eq("rst.m_tvalid", 32'(m_axis.tvalid), 32'd1);
`ifdef AXIS_SWITCH_SEQUENCER_COUNT_EN
    check_eq("rst.swap_count", swap_count, 32'd0);
`endif

    // Plain pass-through for 10 beats with no swap requested.
    do_reset(16'd4);
    for (int i = 0; i < 10; i++) step("pass", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // A swap requested at cnt=1 is applied at the cnt=3 boundary, followed by a two-cycle stall.
    do_reset(16'd4);
    step("sw.c0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("sw.c1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("sw.c2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("sw.c3", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("sw.c4", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step("sw.c5", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step("sw.c6", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef AXIS_SWITCH_SEQUENCER_COUNT_EN
    check_eq("sw.swap_count", swap_count, 32'd1);
`endif

    // A request withdrawn before the boundary causes a busy pulse only.
    do_reset(16'd4);
    step("wd.c0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("wd.c1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step("wd.c2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("wd.c3", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("wd.c4", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Downstream stall while PEND at cnt=3: the swap waits for the stalled boundary beat.
    do_reset(16'd4);
    for (int i = 0; i < 3; i++) step("bp.pre", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("bp.c3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("bp.hold", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("bp.c8",  1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("bp.c9",  1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step("bp.c10", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step("bp.c11", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Length shrinks from 8 to 3 at cnt=5 with a swap pending, so the next beat is a boundary.
    do_reset(16'd8);
    for (int i = 0; i < 5; i++) step("ln.pre", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("ln.c5", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cfg_length = 16'd3;
    step("ln.c6", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("ln.c7", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step("ln.c8", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    // The counter restarted at 0, so a swap back completes after three more beats.
    step("ln.c9",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("ln.c10", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step("ln.c11", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step("ln.c12", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
`ifdef AXIS_SWITCH_SEQUENCER_COUNT_EN
    check_eq("ln.swap_count", swap_count, 32'd2);
`endif

    // Reset asserted during SETTLE aborts the swap immediately.
    do_reset(16'd4);
    step("ra.c0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("ra.c1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("ra.c2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("ra.c3", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    check_eq("ra.settle.m_tvalid", 32'(m_axis.tvalid), 32'd0);
    aresetn = 1'b0;
    #1;
    check_eq("ra.switch",   32'(switch),        32'd0);
    check_eq("ra.busy",     32'(busy),          32'd0);
    check_eq("ra.m_tvalid", 32'(m_axis.tvalid), 32'd1);
`ifdef AXIS_SWITCH_SEQUENCER_COUNT_EN
    check_eq("ra.swap_count", swap_count, 32'd0);
`endif
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
